reg_write_queue: RTL and testbench

REG_WRITE_QUEUE -- requirements
Module: reg_write_queue

---
 rtl/reg_write_queue_pkg.sv | 15 +
 rtl/reg_write_queue_match.sv | 51 +++++
 rtl/reg_write_queue.sv | 84 ++++++++
 tb/tb_reg_write_queue.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/reg_write_queue_pkg.sv
// Shared processor definitions for the register write queue.
//   REG_W    : register-index width
//   DATA_W   : register data width
//   REG_ZERO : hard-wired zero register, never written
//   wrReq_t  : one buffered register write (index + data)
package reg_write_queue_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } wrReq_t;
endpackage

// File: rtl/reg_write_queue_match.sv
// pending_write_match: newest-match search over the queued writes and the
// register-file output register. Only built with REG_WRITE_BYPASS_EN.
//   entries   : queue storage, oldest at rdPtr
//   rdPtr     : head pointer
//   count     : number of valid queued entries
//   outReg/outData/outActive : output register contents and write enable
//   lookupReg : probed index
//   hit/data  : pending write found / its newest data
`ifdef REG_WRITE_BYPASS_EN
module pending_write_match
  import reg_write_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 3
) (
  input  wrReq_t [DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]   rdPtr,
  input  logic [CNT_W-1:0]   count,
  input  logic [REG_W-1:0]   outReg,
  input  logic [DATA_W-1:0]  outData,
  input  logic               outActive,
  input  logic [REG_W-1:0]   lookupReg,
  output logic               hit,
  output logic [DATA_W-1:0]  data
);
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    // Output register is the oldest candidate; queued entries override it.
    if (outActive && outReg == lookupReg) begin
      hit  = 1'b1;
      data = outData;
    end
    // Walk from head to tail so the last match seen is the newest.
    for (int k = 0; k < DEPTH; k++) begin
      idx = rdPtr + PTR_W'(k);
      if (CNT_W'(k) < count && entries[idx].idx == lookupReg) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
    if (lookupReg == REG_ZERO) begin
      hit  = 1'b0;
      data = '0;
    end
  end
endmodule
`endif

// File: rtl/reg_write_queue.sv
// reg_write_queue: FIFO of pending register-file writes drained one per
// cycle when the write port is free. Writes to register 0 are accepted and
// dropped. Optional bypass lookup enabled by macro REG_WRITE_BYPASS_EN.
//   clk, reset            : clock, synchronous active-high reset
//   WriteReqValid/Ready   : producer handshake (Ready = not full)
//   WriteReqReg/Data      : write request
//   DrainEnable           : register-file write port free this cycle
//   WriteReg/WriteData/RegWriteActive : registered register-file write
//   LookupReg/Hit/Data    : pending-write probe (tied 0 without bypass)
module reg_write_queue
  import reg_write_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WriteReqValid,
  output logic              WriteReqReady,
  input  logic [REG_W-1:0]  WriteReqReg,
  input  logic [DATA_W-1:0] WriteReqData,
  input  logic              DrainEnable,
  output logic [REG_W-1:0]  WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWriteActive,
  input  logic [REG_W-1:0]  LookupReg,
  output logic              LookupHit,
  output logic [DATA_W-1:0] LookupData
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wrReq_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]   wrPtr, rdPtr;
  logic [CNT_W-1:0]   count;
  logic               push, pop;

  // Ready looks only at occupancy, never at this cycle's drain.
  assign WriteReqReady = (count != CNT_W'(DEPTH));
  assign push = WriteReqValid && WriteReqReady && (WriteReqReg != REG_ZERO);
  // Pop uses pre-edge occupancy, so a push into an empty queue waits a cycle.
  assign pop  = DrainEnable && (count != '0);

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wrPtr] <= '{idx: WriteReqReg, data: WriteReqData};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr          <= '0;
      rdPtr          <= '0;
      count          <= '0;
      WriteReg       <= '0;
      WriteData      <= '0;
      RegWriteActive <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop) begin
        WriteReg  <= mem[rdPtr].idx;
        WriteData <= mem[rdPtr].data;
        rdPtr     <= rdPtr + PTR_W'(1);
      end
      RegWriteActive <= pop;
      count          <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef REG_WRITE_BYPASS_EN
  pending_write_match #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) uMatch (
    .entries   (mem),
    .rdPtr     (rdPtr),
    .count     (count),
    .outReg    (WriteReg),
    .outData   (WriteData),
    .outActive (RegWriteActive),
    .lookupReg (LookupReg),
    .hit       (LookupHit),
    .data      (LookupData)
  );
`else
  wire unusedLookup = &{1'b0, LookupReg};
  assign LookupHit  = 1'b0;
  assign LookupData = '0;
`endif
endmodule

// File: tb/tb_reg_write_queue.sv
// Directed bench for reg_write_queue (DEPTH = 4).
module tb_reg_write_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        WriteReqValid, WriteReqReady;
  logic [4:0]  WriteReqReg;
  logic [31:0] WriteReqData;
  logic        DrainEnable;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        RegWriteActive;
  logic [4:0]  LookupReg;
  logic        LookupHit;
  logic [31:0] LookupData;

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  reg_write_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .WriteReqValid(WriteReqValid), .WriteReqReady(WriteReqReady),
    .WriteReqReg(WriteReqReg), .WriteReqData(WriteReqData),
    .DrainEnable(DrainEnable),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWriteActive(RegWriteActive),
    .LookupReg(LookupReg), .LookupHit(LookupHit), .LookupData(LookupData)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [4:0] r, input logic [31:0] d);
    WriteReqValid = 1'b1;
    WriteReqReg   = r;
    WriteReqData  = d;
    step();
    WriteReqValid = 1'b0;
  endtask

  initial begin
    int expQ[$];
    int writes, pushedN, curReg;
    bit acc;

    reset = 1'b1; WriteReqValid = 1'b0; WriteReqReg = '0; WriteReqData = '0;
    DrainEnable = 1'b0; LookupReg = '0;
    step(); step();
    reset = 1'b0;
    chk("rstWriteReg", 64'(WriteReg), 0);
    chk("rstWriteData", 64'(WriteData), 0);
    chk("rstActive", 64'(RegWriteActive), 0);
    chk("rstReady", 64'(WriteReqReady), 1);

    // Single write, minimum latency
    DrainEnable = 1'b1;
    push1(5'd16, 32'h8000_0000);
    chk("latN", 64'(RegWriteActive), 0);
    step();
    chk("latWrite", {27'(0), WriteReg, WriteData}, {27'(0), 5'd16, 32'h8000_0000});
    chk("latActive", 64'(RegWriteActive), 1);
    step();
    chk("latIdle", 64'(RegWriteActive), 0);
    chk("latHold", 64'(WriteReg), 16);

`ifndef REG_WRITE_BYPASS_EN
    LookupReg = 5'd16; #1;
    chk("tieHit", 64'(LookupHit), 0);
    chk("tieData", 64'(LookupData), 0);
`endif

    // Fill, then drain in order
    DrainEnable = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("fillReady", 64'(WriteReqReady), 1);
      push1(5'(i), 32'(i * 32'h11));
    end
    chk("fullReady", 64'(WriteReqReady), 0);
    push1(5'd7, 32'h77);  // offered while full, must be refused
    chk("fullHold", 64'(WriteReqReady), 0);
    chk("fullNoWrite", 64'(RegWriteActive), 0);
    DrainEnable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("drainWrite", {27'(0), WriteReg, WriteData}, {27'(0), 5'(i), 32'(i * 32'h11)});
      chk("drainActive", 64'(RegWriteActive), 1);
    end
    step();
    chk("drainDone", 64'(RegWriteActive), 0);

    // Register 0 dropped
    chk("r0Ready", 64'(WriteReqReady), 1);
    push1(5'd0, 32'h112);
    for (int i = 0; i < 3; i++) begin
      chk("r0NoWrite", 64'(RegWriteActive), 0);
      step();
    end
    chk("r0Ready2", 64'(WriteReqReady), 1);

    // Reset while full, with a push and drain pending
    DrainEnable = 1'b0;
    for (int i = 5; i <= 8; i++) push1(5'(i), 32'(i));
    chk("fill2Ready", 64'(WriteReqReady), 0);
    reset = 1'b1; WriteReqValid = 1'b1; WriteReqReg = 5'd9; WriteReqData = 32'h99;
    DrainEnable = 1'b1;
    step();
    reset = 1'b0; WriteReqValid = 1'b0;
    chk("rst2WriteReg", 64'(WriteReg), 0);
    chk("rst2WriteData", 64'(WriteData), 0);
    chk("rst2Active", 64'(RegWriteActive), 0);
    chk("rst2Ready", 64'(WriteReqReady), 1);
    step();
    chk("rst2Empty", 64'(RegWriteActive), 0);
    step();
    chk("rst2Empty2", 64'(RegWriteActive), 0);

    // Full queue, drain with producer held valid
    DrainEnable = 1'b0;
    for (int i = 10; i <= 13; i++) begin
      push1(5'(i), 32'h100 + 32'(i));
      expQ.push_back(i);
    end
    DrainEnable = 1'b1;
    curReg = 14; pushedN = 0; writes = 0;
    WriteReqValid = 1'b1; WriteReqReg = 5'(curReg); WriteReqData = 32'h100 + 32'(curReg);
    chk("fullDrainReady", 64'(WriteReqReady), 0);
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc = WriteReqValid && WriteReqReady;
      step();
      if (acc) begin
        expQ.push_back(curReg);
        pushedN++;
        if (pushedN == 6) WriteReqValid = 1'b0;
        else begin
          curReg++;
          WriteReqReg = 5'(curReg); WriteReqData = 32'h100 + 32'(curReg);
        end
      end
      if (RegWriteActive) begin
        writes++;
        if (expQ.size() == 0) chk("streamSpurious", 1, 0);
        else begin
          int e;
          e = expQ.pop_front();
          chk("streamOrder", {27'(0), WriteReg, WriteData}, {27'(0), 5'(e), 32'h100 + 32'(e)});
        end
      end
    end
    chk("streamWrites", 64'(writes), 10);
    chk("streamLeft", 64'(expQ.size()), 0);

`ifdef REG_WRITE_BYPASS_EN
    DrainEnable = 1'b0;
    push1(5'd9, 32'hA);
    push1(5'd9, 32'hB);
    LookupReg = 5'd9; #1;
    chk("bypHit", 64'(LookupHit), 1);
    chk("bypData", 64'(LookupData), 32'hB);
    LookupReg = 5'd5; #1;
    chk("bypMiss", 64'(LookupHit), 0);
    LookupReg = 5'd0; #1;
    chk("bypZero", 64'(LookupHit), 0);
    LookupReg = 5'd9;
    DrainEnable = 1'b1;
    step();
    chk("bypQueueWins", {31'(0), LookupHit, LookupData}, {31'(0), 1'b1, 32'hB});
    step();
    chk("bypOutReg", {31'(0), LookupHit, LookupData}, {31'(0), 1'b1, 32'hB});
    step();
    chk("bypGone", 64'(LookupHit), 0);
    DrainEnable = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
